// File: rtl/pipelined_adder_sub.sv
// pipelined_adder_sub: CHUNK-bit ripple slices, one slice per stage,
// valid/ready handshake with a single global stall enable.
module pipelined_adder_sub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int STAGES = WIDTH / CHUNK;

  logic                         en;
  logic [STAGES-1:0]            v;
  logic [STAGES:0]              v_shift;
  logic [STAGES-1:0]            rc;
  logic [STAGES-1:0]            nc;
  logic [STAGES-1:0][WIDTH-1:0] ra;
  logic [STAGES-1:0][WIDTH-1:0] rb;
  logic [STAGES-1:0][WIDTH-1:0] rs;
  logic [STAGES-1:0][WIDTH-1:0] na;
  logic [STAGES-1:0][WIDTH-1:0] nb;
  logic [STAGES-1:0][WIDTH-1:0] ns;
  logic                         ro;
  logic                         nov;
  logic                         unused_tail;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign v_shift  = {v, in_valid};

  // b is inverted once at entry so every slice is a plain add
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] ss;
    logic             sc;
    logic [CHUNK:0]   part;

    if (k == 0) begin : g_head
      assign sa = a;
      assign sb = sub ? ~b : b;
      assign sc = sub | c_in;
      assign ss = '0;
    end else begin : g_body
      assign sa = ra[k-1];
      assign sb = rb[k-1];
      assign sc = rc[k-1];
      assign ss = rs[k-1];
    end

    assign part = {1'b0, sa[k*CHUNK +: CHUNK]}
                + {1'b0, sb[k*CHUNK +: CHUNK]}
                + {{CHUNK{1'b0}}, sc};

    assign na[k] = sa;
    assign nb[k] = sb;
    assign nc[k] = part[CHUNK];
    assign ns[k] = ss
                 | (WIDTH'(part[CHUNK-1:0]) << (k*CHUNK));
  end

  // carry into MSB recovered as a ^ b ^ sum at the top bit
  assign nov = na[STAGES-1][WIDTH-1]
             ^ nb[STAGES-1][WIDTH-1]
             ^ ns[STAGES-1][WIDTH-1]
             ^ nc[STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v  <= '0;
      ra <= '0;
      rb <= '0;
      rs <= '0;
      rc <= '0;
      ro <= 1'b0;
    end else if (en) begin
      v  <= v_shift[STAGES-1:0];
      ra <= na;
      rb <= nb;
      rs <= ns;
      rc <= nc;
      ro <= nov;
    end
  end

  assign unused_tail = ^{ra[STAGES-1], rb[STAGES-1],
                         v_shift[STAGES]};

  assign out_valid = v[STAGES-1];
  assign sum       = rs[STAGES-1];
  assign c_out     = rc[STAGES-1];
  assign ovf       = ro;

endmodule

// File: tb/tb_pipelined_adder_sub.sv
// tb_pipelined_adder_sub: random and directed operations
// scored in order against an arithmetic reference model.
module tb_pipelined_adder_sub;

  localparam int W   = 32;
  localparam int LAT = 4;

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b0;
  logic         in_valid  = 1'b0;
  logic         in_ready;
  logic [W-1:0] a         = '0;
  logic [W-1:0] b         = '0;
  logic         c_in      = 1'b0;
  logic         sub       = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ovf;

  int          n_chk  = 0;
  int          n_pass = 0;
  int          cyc    = 0;
  bit          lat_on = 1'b0;
  logic [33:0] exp_q[$];
  int          acc_q[$];

  pipelined_adder_sub #(.WIDTH(W), .CHUNK(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string tag, logic [63:0] got,
                       logic [63:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  // {ovf, c_out, sum} from unsigned and signed arithmetic
  function automatic logic [33:0] model(logic [31:0] x,
                                        logic [31:0] y,
                                        logic ci, logic s);
    logic [32:0] u;
    longint      sv;
    logic        o;
    if (s) begin
      u  = {x >= y, x - y};
      sv = longint'($signed(x)) - longint'($signed(y));
    end else begin
      u  = {1'b0, x} + {1'b0, y} + {32'b0, ci};
      sv = longint'($signed(x)) + longint'($signed(y))
         + longint'(ci);
    end
    o = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
    return {o, u};
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      acc_q.delete();
    end else begin
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, c_in, sub));
        acc_q.push_back(cyc);
      end
      if (exp_q.size() == 0) begin
        check("idle_valid", 64'(out_valid), 64'd0);
      end else if (out_valid && out_ready) begin
        logic [33:0] e;
        int          ac;
        e  = exp_q.pop_front();
        ac = acc_q.pop_front();
        check("result", 64'({ovf, c_out, sum}), 64'(e));
        if (lat_on)
          check("latency", 64'(cyc - ac), 64'(LAT));
      end
    end
  end

  task automatic send(logic [31:0] x, logic [31:0] y,
                      logic ci, logic s);
    bit done;
    done     = 1'b0;
    a        = x;
    b        = y;
    c_in     = ci;
    sub      = s;
    in_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("accepted", 64'(done), 64'd1);
  endtask

  task automatic send_rand();
    send($urandom, $urandom, 1'($urandom_range(0, 1)),
         1'($urandom_range(0, 1)));
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #2;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_outs(string tag);
    check({tag, "_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_sum"},   64'(sum),       64'd0);
    check({tag, "_cout"},  64'(c_out),     64'd0);
    check({tag, "_ovf"},   64'(ovf),       64'd0);
    check({tag, "_ready"}, 64'(in_ready),  64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [33:0] held;

    repeat (2) @(posedge clk);
    #1;
    check_reset_outs("rst");
    rst_n     = 1'b1;
    out_ready = 1'b1;
    lat_on    = 1'b1;

    send(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
    drain();
    send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
    drain();
    send(32'h5, 32'h7, 1'b1, 1'b1);
    drain();
    send(32'h8000_0000, 32'h1, 1'b0, 1'b1);
    drain();

    for (int i = 0; i < 16; i++) send_rand();
    drain();

    lat_on    = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_rand();
    a        = $urandom;
    b        = $urandom;
    c_in     = 1'b1;
    sub      = 1'b0;
    in_valid = 1'b1;
    held     = {ovf, c_out, sum};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_ready", 64'(in_ready), 64'd0);
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_hold", 64'({ovf, c_out, sum}), 64'(held));
    end
    out_ready = 1'b1;
    send(a, b, c_in, sub);
    drain();

    lat_on = 1'b1;
    for (int i = 0; i < 3; i++) send_rand();
    rst_n = 1'b0;
    #1;
    check_reset_outs("flush");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    send(32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
